led7seg_scan4: RTL and testbench

//  Four-digit time-multiplexed scan driver that sits directly upstream of the per-digit
//  7-segment decoder. Holds a 16-bit BCD/hex display word and cycles through its four

---
 rtl/led7seg_pkg.sv | 26 ++
 rtl/led7seg_scan4_prescaler.sv | 29 ++
 rtl/led7seg_scan4.sv | 88 ++++++++
 tb/tb_led7seg_scan4.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/led7seg_pkg.sv
// Shared constants and select helpers for the four-digit 7-segment scan driver.
// SA is active-low and tri-stated: a lit digit pulls its bit to 0 and every other bit floats.
package led7seg_pkg;

  localparam int NDIG  = 4;
  localparam int NIB_W = 4;

  localparam logic [NDIG-1:0] SA_OFF = 4'bzzzz;

  // One-hot enable, 2-state, for the select drivers.
  function automatic logic [NDIG-1:0] sel_onehot(input logic [1:0] idx);
    logic [NDIG-1:0] r;
    r      = '0;
    r[idx] = 1'b1;
    return r;
  endfunction

  // Resolved select pattern with Z on every inactive bit.
  function automatic logic [NDIG-1:0] sa_onehot0(input logic [1:0] idx);
    logic [NDIG-1:0] r;
    r      = SA_OFF;
    r[idx] = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/led7seg_scan4_prescaler.sv
// Digit-slot prescaler: counts 0..SCAN_DIV-1 while enabled and flags the last count.
// The counter holds its value while en=0, so scanning resumes mid-slot.
module led7seg_prescaler #(
  parameter int SCAN_DIV = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam int            PW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(SCAN_DIV - 1);

  logic [PW-1:0] presc;

  // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc <= '0;
    end else if (en) begin
      // Explicit wrap: SCAN_DIV need not be a power of two.
      presc <= (presc == LAST) ? '0 : presc + 1'b1;
    end
  end

  assign tick = en & (presc == LAST);

endmodule

// File: rtl/led7seg_scan4.sv
// Four-digit multiplexed scan driver: tear-free word loading at frame boundaries,
// one dead cycle per slot change and optional leading-zero blanking.
module led7seg_scan4
  import led7seg_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter bit LZ_BLANK = 1'b1
) (
  input  logic                    CLK,
  input  logic                    RSTN,
  input  logic                    EN,
  input  logic                    LD_VALID,
  input  logic [NDIG*NIB_W-1:0]   LD_DATA,
  output logic                    LD_READY,
  output logic [NIB_W-1:0]        DIGIT,
  output wire  [NDIG-1:0]         SA
);

  logic                    tick;
  logic                    frame_end;
  logic                    accept;
  logic [1:0]              idx;
  logic [1:0]              idx_n;
  logic [NDIG*NIB_W-1:0]   disp;
  logic [NDIG*NIB_W-1:0]   pend;
  logic                    pend_full;
  logic [NDIG-1:0]         nib_nz;
  logic                    blank_n;
  logic [NDIG-1:0]         sa_on;

  led7seg_prescaler #(
    .SCAN_DIV (SCAN_DIV)
  ) u_presc (
    .clk   (CLK),
    .rst_n (RSTN),
    .en    (EN),
    .tick  (tick)
  );

  // 2-bit index wraps 3->0 on its own.
  assign idx_n     = idx + {1'b0, tick};
  assign frame_end = tick & (idx == 2'd3);
  assign LD_READY  = ~pend_full;
  assign accept    = LD_VALID & LD_READY;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    nib_nz  = '0;
    for (int i = 0; i < NDIG; i++) begin
      nib_nz[i] = |disp[NIB_W*i +: NIB_W];
    end
    // Blank digit i when it and every digit to its left are zero; digit0 always shows.
    blank_n = LZ_BLANK && (idx_n != 2'd0) && !(|(nib_nz >> idx_n));
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      idx       <= '0;
      disp      <= '0;
      pend_full <= 1'b0;
      DIGIT     <= '0;
      sa_on     <= '0;
    end else begin
      idx <= idx_n;
      // Registered pend_full means an accept on the frame_end cycle waits a whole frame.
      if (accept) begin
        pend_full <= 1'b1;
      end else if (frame_end && pend_full) begin
        disp      <= pend;
        pend_full <= 1'b0;
      end
      DIGIT <= disp[NIB_W*idx_n +: NIB_W];
      sa_on <= (tick || !EN || blank_n) ? '0 : sel_onehot(idx_n);
    end
  end

  // NOTE: the pending data register has no reset; pend_full alone marks it valid.
  always_ff @(posedge CLK) begin
    if (accept) begin
      pend <= LD_DATA;
    end
  end

  for (genvar i = 0; i < NDIG; i++) begin : g_sa
    assign SA[i] = sa_on[i] ? 1'b0 : 1'bz;
  end

endmodule

// File: tb/tb_led7seg_scan4.sv
// Directed bench for led7seg_scan4 with SCAN_DIV=4; a second instance runs LZ_BLANK=0.
// SA nets carry pullups, so a floating select bit reads back as 1.
module tb_led7seg_scan4;

  logic        clk = 1'b0;
  logic        rstn;
  logic        en;
  logic        ld_valid;
  logic [15:0] ld_data;
  logic        ld_ready, ld_ready_z;
  logic [3:0]  digit, digit_z;
  wire  [3:0]  sa, sa_z;

  int n_chk  = 0;
  int n_pass = 0;

  pullup (sa[0]);
  pullup (sa[1]);
  pullup (sa[2]);
  pullup (sa[3]);
  pullup (sa_z[0]);
  pullup (sa_z[1]);
  pullup (sa_z[2]);
  pullup (sa_z[3]);

  always #5 clk = ~clk;

  led7seg_scan4 #(.SCAN_DIV(4), .LZ_BLANK(1'b1)) dut (
    .CLK      (clk),
    .RSTN     (rstn),
    .EN       (en),
    .LD_VALID (ld_valid),
    .LD_DATA  (ld_data),
    .LD_READY (ld_ready),
    .DIGIT    (digit),
    .SA       (sa)
  );

  led7seg_scan4 #(.SCAN_DIV(4), .LZ_BLANK(1'b0)) dut_nb (
    .CLK      (clk),
    .RSTN     (rstn),
    .EN       (en),
    .LD_VALID (ld_valid),
    .LD_DATA  (ld_data),
    .LD_READY (ld_ready_z),
    .DIGIT    (digit_z),
    .SA       (sa_z)
  );

  localparam logic [3:0] OFF = 4'b1111;
  localparam logic [3:0] D0  = 4'b1110;
  localparam logic [3:0] D1  = 4'b1101;
  localparam logic [3:0] D2  = 4'b1011;
  localparam logic [3:0] D3  = 4'b0111;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic adv(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rstn = 1'b0; en = 1'b1; ld_valid = 1'b0; ld_data = 16'h0000;
    adv(3);
    check("rst_sa", sa, OFF);
    check("rst_digit", digit, 4'h0);
    check("rst_ready", {3'b0, ld_ready}, 4'h1);
    rstn = 1'b1;
    check("first_cycle_sa", sa, OFF);

    // 1: digit0 lit with 0, others blanked
    adv(1);                                   // E0
    check("e0_sa", sa, D0);
    check("e0_digit", digit, 4'h0);
    check("e0_ready", {3'b0, ld_ready}, 4'h1);
    adv(1);                                   // E1
    ld_valid = 1'b1; ld_data = 16'h1234;
    adv(1);                                   // E2: accepted
    ld_valid = 1'b0;
    check("ld1_ready_low", {3'b0, ld_ready}, 4'h0);
    check("e2_sa", sa, D0);
    adv(1);                                   // E3: dead cycle
    check("e3_dead", sa, OFF);
    adv(1);                                   // E4: idx1 blanked
    check("e4_blank", sa, OFF);
    check("e4_digit", digit, 4'h0);

    // 2: 1234 lands at frame_end E15
    adv(11);                                  // E15
    check("e15_ready", {3'b0, ld_ready}, 4'h1);
    check("e15_sa", sa, OFF);
    check("e15_digit_old", digit, 4'h0);
    adv(1);                                   // E16
    check("f1_d0_sa", sa, D0);
    check("f1_d0_dig", digit, 4'h4);
    adv(3);                                   // E19
    check("f1_dead_sa", sa, OFF);
    check("f1_dead_dig", digit, 4'h3);
    adv(1);                                   // E20
    check("f1_d1_sa", sa, D1);
    check("f1_d1_dig", digit, 4'h3);
    adv(4);                                   // E24
    check("f1_d2_sa", sa, D2);
    check("f1_d2_dig", digit, 4'h2);
    adv(4);                                   // E28
    check("f1_d3_sa", sa, D3);
    check("f1_d3_dig", digit, 4'h1);

    // 3: 0050 with and without blanking
    ld_valid = 1'b1; ld_data = 16'h0050;
    adv(1);                                   // E29
    ld_valid = 1'b0;
    check("ld2_ready_low", {3'b0, ld_ready}, 4'h0);
    adv(3);                                   // E32
    check("ld2_ready_back", {3'b0, ld_ready}, 4'h1);
    check("f2_d0_sa", sa, D0);
    check("f2_d0_dig", digit, 4'h0);
    check("nb_d0_sa", sa_z, D0);
    adv(4);                                   // E36
    check("f2_d1_sa", sa, D1);
    check("f2_d1_dig", digit, 4'h5);
    check("nb_d1_dig", digit_z, 4'h5);
    adv(4);                                   // E40
    check("f2_d2_blank", sa, OFF);
    check("nb_d2_sa", sa_z, D2);
    check("nb_d2_dig", digit_z, 4'h0);
    adv(4);                                   // E44
    check("f2_d3_blank", sa, OFF);
    check("nb_d3_sa", sa_z, D3);

    // 4: accept on the frame_end cycle defers by a frame; held word waits
    adv(2);                                   // E46
    ld_valid = 1'b1; ld_data = 16'hAAAA;
    adv(1);                                   // E47: accept + frame_end
    check("fe_acc_ready", {3'b0, ld_ready}, 4'h0);
    ld_data = 16'hBBBB;
    adv(1);                                   // E48
    check("fe_acc_d0", digit, 4'h0);
    check("fe_acc_sa", sa, D0);
    adv(4);                                   // E52
    check("fe_acc_d1_old", digit, 4'h5);
    adv(10);                                  // E62
    check("hold_ready_low", {3'b0, ld_ready}, 4'h0);
    adv(1);                                   // E63: AAAA transferred
    check("xfer_ready", {3'b0, ld_ready}, 4'h1);
    adv(1);                                   // E64: BBBB accepted
    ld_valid = 1'b0;
    check("bbbb_acc_ready", {3'b0, ld_ready}, 4'h0);
    check("aaaa_d0", digit, 4'hA);
    check("aaaa_sa", sa, D0);
    adv(4);                                   // E68
    check("aaaa_d1", digit, 4'hA);
    check("aaaa_d1_sa", sa, D1);
    adv(12);                                  // E80
    check("bbbb_d0", digit, 4'hB);
    check("bbbb_sa", sa, D0);
    check("bbbb_ready", {3'b0, ld_ready}, 4'h1);

    // 5: EN low freezes presc/idx and darkens the display
    en = 1'b0;
    adv(3);                                   // E83
    check("en0_sa", sa, OFF);
    check("en0_dig", digit, 4'hB);
    en = 1'b1;
    adv(1);                                   // E84
    check("en1_sa_a", sa, D0);
    adv(1);                                   // E85
    check("en1_sa_b", sa, D0);
    adv(1);                                   // E86
    check("en1_dead", sa, OFF);
    adv(1);                                   // E87
    check("en1_d1_sa", sa, D1);
    check("en1_d1_dig", digit, 4'hB);

    // 6: reset with a pending word discards it
    ld_valid = 1'b1; ld_data = 16'h9876;
    adv(1);                                   // E88
    ld_valid = 1'b0;
    check("pend_ready_low", {3'b0, ld_ready}, 4'h0);
    rstn = 1'b0;
    adv(1);                                   // E89
    check("rst2_sa", sa, OFF);
    check("rst2_dig", digit, 4'h0);
    check("rst2_ready", {3'b0, ld_ready}, 4'h1);
    check("rst2_nb_sa", sa_z, OFF);
    adv(1);                                   // E90
    rstn = 1'b1;
    adv(1);                                   // new E0
    check("rel_sa", sa, D0);
    check("rel_dig", digit, 4'h0);
    adv(16);                                  // new E16, after first frame_end
    check("lost_sa", sa, D0);
    check("lost_dig", digit, 4'h0);
    check("lost_ready", {3'b0, ld_ready}, 4'h1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
